// File: rtl/rst_seq_gen_pkg.sv
// Shared encodings and sizing helpers for the staged reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } seq_state_e;

    localparam int RCNT_W = 8;
    localparam logic [RCNT_W-1:0] RCNT_MAX = '1;

    // Never returns 0 so the HOLD_CYC=STAGE_CYC=1 corner still gets a real counter.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/rst_seq_gen_if.sv
// Bundle of the sequencer's control/status signals for bench and integration wiring.
interface rst_seq_gen_if
    import rst_seq_pkg::*;
#(
    parameter int NUM_RST = 4
);
    logic               lock_in;
    logic               soft_rst_req;
    logic [NUM_RST-1:0] sub_rst;
    logic               seq_done;
    logic [1:0]         seq_state;
    logic [RCNT_W-1:0]  restart_cnt;

    modport master (
        output lock_in, soft_rst_req,
        input  sub_rst, seq_done, seq_state, restart_cnt
    );

    modport slave (
        input  lock_in, soft_rst_req,
        output sub_rst, seq_done, seq_state, restart_cnt
    );
endinterface

// File: rtl/rst_seq_gen_sync.sv
// One-bit two-flop synchroniser with synchronous active-high reset.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic ff1_q;
    logic ff2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;
endmodule

// File: rtl/rst_seq_gen.sv
// Staged reset sequencer: waits for a stable lock, then releases sub_rst bits
// one at a time, re-asserting everything on lock loss or a software request.
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int NUM_RST   = 4,
    parameter int HOLD_CYC  = 16,
    parameter int STAGE_CYC = 8
) (
    input  logic               pl_clk,
    input  logic               pl_rst,
    input  logic               lock_in,
    input  logic               soft_rst_req,
    output logic [NUM_RST-1:0] sub_rst,
    output logic               seq_done,
    output logic [1:0]         seq_state,
    output logic [RCNT_W-1:0]  restart_cnt
);
    localparam int CNT_W = cnt_width(HOLD_CYC, STAGE_CYC);
    localparam int IDX_W = $clog2(NUM_RST) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_RST - 1);

    logic lock_s;

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [NUM_RST-1:0] sub_q,   sub_d;
    logic               done_q,  done_d;
    logic [RCNT_W-1:0]  rcnt_q,  rcnt_d;

    sync_2ff u_lock_sync (
        .clk_i (pl_clk),
        .rst_i (pl_rst),
        .d_i   (lock_in),
        .q_o   (lock_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sub_d   = sub_q;
        done_d  = done_q;
        rcnt_d  = rcnt_q;

        if (state_q == ST_ASSERT) begin
            sub_d  = '1;
            done_d = 1'b0;
            cnt_d  = '0;
            idx_d  = '0;
            if (lock_s) state_d = ST_HOLD;
        end else if (!lock_s || soft_rst_req) begin
            // Lock loss outranks the soft request; only loss out of RUN is counted.
            state_d = ST_ASSERT;
            sub_d   = '1;
            done_d  = 1'b0;
            cnt_d   = '0;
            idx_d   = '0;
            if (!lock_s && state_q == ST_RUN && rcnt_q != RCNT_MAX)
                rcnt_d = rcnt_q + RCNT_W'(1);
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_RELEASE;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == STAGE_LAST) begin
                        sub_d = sub_q & ~(NUM_RST'(1) << idx_q);
                        cnt_d = '0;
                        idx_d = idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pl_clk) begin
        if (pl_rst) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            sub_q   <= '1;
            done_q  <= 1'b0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sub_q   <= sub_d;
            done_q  <= done_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign sub_rst     = sub_q;
    assign seq_done    = done_q;
    assign seq_state   = state_q;
    assign restart_cnt = rcnt_q;
endmodule

// File: tb/tb_rst_seq_gen.sv
// Scoreboarded bench: default-parameter DUT plus a 1/1/1 sweep instance on shared inputs.
module tb_rst_seq_gen;
    import rst_seq_pkg::*;

    typedef struct {
        int         cyc;
        int         w;
        logic [7:0] sub;
        logic       done;
        logic [1:0] st;
        logic [7:0] rc;
    } exp_t;

    logic pl_clk;
    logic pl_rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    rst_seq_gen_if #(.NUM_RST(4)) bus ();

    logic             sub1;
    logic             done1;
    logic [1:0]       st1;
    logic [RCNT_W-1:0] rc1;

    rst_seq_gen #(.NUM_RST(4), .HOLD_CYC(16), .STAGE_CYC(8)) dut (
        .pl_clk       (pl_clk),
        .pl_rst       (pl_rst),
        .lock_in      (bus.lock_in),
        .soft_rst_req (bus.soft_rst_req),
        .sub_rst      (bus.sub_rst),
        .seq_done     (bus.seq_done),
        .seq_state    (bus.seq_state),
        .restart_cnt  (bus.restart_cnt)
    );

    rst_seq_gen #(.NUM_RST(1), .HOLD_CYC(1), .STAGE_CYC(1)) dut_min (
        .pl_clk       (pl_clk),
        .pl_rst       (pl_rst),
        .lock_in      (bus.lock_in),
        .soft_rst_req (bus.soft_rst_req),
        .sub_rst      (sub1),
        .seq_done     (done1),
        .seq_state    (st1),
        .restart_cnt  (rc1)
    );

    initial pl_clk = 1'b0;
    always #5 pl_clk = ~pl_clk;
    always @(posedge pl_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic push(input int c, input int w, input logic [7:0] s, input logic d,
                        input logic [1:0] st, input logic [7:0] rc);
        exp_t e;
        e.cyc = c; e.w = w; e.sub = s; e.done = d; e.st = st; e.rc = rc;
        sb.push_back(e);
    endtask

    // Full nominal release timeline relative to the lock-sampling edge t0.
    task automatic push_seq(input int t0, input logic [7:0] rc, input bit sweep);
        push(t0, 0, 8'hF, 1'b0, 2'd1, rc);
        if (sweep) begin
            push(t0 + 1, 1, 8'h1, 1'b0, 2'd2, 8'd0);
            push(t0 + 2, 1, 8'h0, 1'b1, 2'd3, 8'd0);
        end
        push(t0 + 15, 0, 8'hF, 1'b0, 2'd1, rc);
        push(t0 + 16, 0, 8'hF, 1'b0, 2'd2, rc);
        push(t0 + 23, 0, 8'hF, 1'b0, 2'd2, rc);
        push(t0 + 24, 0, 8'hE, 1'b0, 2'd2, rc);
        push(t0 + 32, 0, 8'hC, 1'b0, 2'd2, rc);
        push(t0 + 40, 0, 8'h8, 1'b0, 2'd2, rc);
        push(t0 + 47, 0, 8'h8, 1'b0, 2'd2, rc);
        push(t0 + 48, 0, 8'h0, 1'b1, 2'd3, rc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge pl_clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge pl_clk);
        chk("sb_drain", sb.size(), 0);
    endtask

    always @(negedge pl_clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                chk("sb_late", e.cyc, cyc);
            end else if (e.w == 0) begin
                chk($sformatf("sub_rst@%0d", e.cyc),     32'(bus.sub_rst),     32'(e.sub));
                chk($sformatf("seq_done@%0d", e.cyc),    32'(bus.seq_done),    32'(e.done));
                chk($sformatf("seq_state@%0d", e.cyc),   32'(bus.seq_state),   32'(e.st));
                chk($sformatf("restart_cnt@%0d", e.cyc), 32'(bus.restart_cnt), 32'(e.rc));
            end else begin
                chk($sformatf("min_sub_rst@%0d", e.cyc),   32'(sub1),  32'(e.sub));
                chk($sformatf("min_seq_done@%0d", e.cyc),  32'(done1), 32'(e.done));
                chk($sformatf("min_seq_state@%0d", e.cyc), 32'(st1),   32'(e.st));
                chk($sformatf("min_rcnt@%0d", e.cyc),      32'(rc1),   32'(e.rc));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int c;
        pl_rst = 1'b1;
        bus.lock_in = 1'b0;
        bus.soft_rst_req = 1'b0;
        tick(3);

        // Reset hold, even with lock and soft request active.
        bus.lock_in = 1'b1;
        bus.soft_rst_req = 1'b1;
        push(cyc + 1, 0, 8'hF, 1'b0, 2'd0, 8'd0);
        push(cyc + 1, 1, 8'h1, 1'b0, 2'd0, 8'd0);
        push(cyc + 2, 0, 8'hF, 1'b0, 2'd0, 8'd0);
        tick(2);
        bus.soft_rst_req = 1'b0;

        // Lock glitch in HOLD restarts the whole sequence without counting.
        pl_rst = 1'b0;
        t0 = cyc + 3;
        push(t0, 0, 8'hF, 1'b0, 2'd1, 8'd0);
        push(t0 + 12, 0, 8'hF, 1'b0, 2'd1, 8'd0);
        push(t0 + 13, 0, 8'hF, 1'b0, 2'd0, 8'd0);
        tick(t0 + 10 - cyc);
        bus.lock_in = 1'b0;
        tick(3);
        bus.lock_in = 1'b1;
        push_seq(cyc + 3, 8'd0, 1'b0);
        drain();

        // Clean nominal run including the 1/1/1 instance.
        pl_rst = 1'b1;
        push(cyc + 1, 0, 8'hF, 1'b0, 2'd0, 8'd0);
        push(cyc + 1, 1, 8'h1, 1'b0, 2'd0, 8'd0);
        tick(2);
        pl_rst = 1'b0;
        push_seq(cyc + 3, 8'd0, 1'b1);
        drain();

        // Soft request in RUN: back to ASSERT, not counted.
        c = cyc;
        bus.soft_rst_req = 1'b1;
        push(c + 1, 0, 8'hF, 1'b0, 2'd0, 8'd0);
        push_seq(c + 2, 8'd0, 1'b0);
        tick(1);
        bus.soft_rst_req = 1'b0;
        drain();

        // Lock loss in RUN, then a soft pulse while parked in ASSERT.
        c = cyc;
        bus.lock_in = 1'b0;
        push(c + 2, 0, 8'h0, 1'b1, 2'd3, 8'd0);
        push(c + 3, 0, 8'hF, 1'b0, 2'd0, 8'd1);
        push(c + 5, 0, 8'hF, 1'b0, 2'd0, 8'd1);
        push(c + 6, 0, 8'hF, 1'b0, 2'd0, 8'd1);
        tick(4);
        bus.soft_rst_req = 1'b1;
        tick(1);
        bus.soft_rst_req = 1'b0;
        tick(1);
        bus.lock_in = 1'b1;
        push_seq(cyc + 3, 8'd1, 1'b0);
        drain();

        // Repeated losses until 300 total; counter saturates at 255.
        for (int i = 2; i <= 300; i++) begin
            c = cyc;
            bus.lock_in = 1'b0;
            push(c + 3, 0, 8'hF, 1'b0, 2'd0, (i > 255) ? 8'd255 : 8'(i));
            tick(3);
            bus.lock_in = 1'b1;
            tick(52);
        end
        push(cyc + 1, 0, 8'h0, 1'b1, 2'd3, 8'd255);
        drain();

        // pl_rst, soft request and lock drop together mid-RELEASE.
        c = cyc;
        bus.lock_in = 1'b0;
        push(c + 3, 0, 8'hF, 1'b0, 2'd0, 8'd255);
        tick(3);
        bus.lock_in = 1'b1;
        t0 = cyc + 3;
        push(t0 + 24, 0, 8'hE, 1'b0, 2'd2, 8'd255);
        push(t0 + 29, 0, 8'hE, 1'b0, 2'd2, 8'd255);
        push(t0 + 30, 0, 8'hF, 1'b0, 2'd0, 8'd0);
        push(t0 + 31, 0, 8'hF, 1'b0, 2'd0, 8'd0);
        tick(t0 + 29 - cyc);
        pl_rst = 1'b1;
        bus.soft_rst_req = 1'b1;
        bus.lock_in = 1'b0;
        tick(1);
        bus.soft_rst_req = 1'b0;
        tick(1);
        pl_rst = 1'b0;
        bus.lock_in = 1'b1;
        push_seq(cyc + 3, 8'd0, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rst_seq_gen.md
RST_SEQ_GEN -- requirements
Module: rst_seq_gen

Interface
REQ-001 SHALL have parameter NUM_RST, default 4: number of staged reset outputs, legal range 1..8.
REQ-002 SHALL have parameter HOLD_CYC, default 16: cycles lock must stay stable before any release, minimum 1.
REQ-003 SHALL have parameter STAGE_CYC, default 8: cycles between consecutive reset releases, minimum 1.
REQ-004 SHALL have port pl_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port pl_rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port lock_in, input, 1 bit: clock-source locked flag, asynchronous to pl_clk.
REQ-007 SHALL have port soft_rst_req, input, 1 bit: single-cycle software re-sequence request.
REQ-008 SHALL have port sub_rst, output, NUM_RST bits: staged active-high resets to downstream logic.
REQ-009 SHALL have port seq_done, output, 1 bit: high when all sub_rst bits are released.
REQ-010 SHALL have port seq_state, output, 2 bits: current FSM state encoding.
REQ-011 SHALL have port restart_cnt, output, 8 bits: count of lock-loss events seen in RUN.

Function
REQ-012 SHALL synchronise lock_in through two flops into lock_s; all decisions use lock_s only.
REQ-013 SHALL implement FSM states ASSERT=0, HOLD=1, RELEASE=2, RUN=3.
REQ-014 In ASSERT, all sub_rst bits SHALL be 1 and seq_done 0; when lock_s=1, move to HOLD with the cycle counter cleared.
REQ-015 In HOLD, the counter SHALL increment each cycle; at count HOLD_CYC-1, move to RELEASE with the counter and stage index cleared.
REQ-016 In RELEASE, at count STAGE_CYC-1 the block SHALL clear sub_rst[idx], increment idx, and clear the counter; bits release in order 0 to NUM_RST-1.
REQ-017 On clearing sub_rst[NUM_RST-1], the block SHALL enter RUN and set seq_done=1 on the same edge.
REQ-018 Timing: if T0 is the edge at which ASSERT samples lock_s=1, sub_rst[k] SHALL be low after edge T0+HOLD_CYC+(k+1)*STAGE_CYC.
REQ-019 If lock_s=0 in HOLD, RELEASE or RUN, the next edge SHALL enter ASSERT, set all sub_rst to 1, clear seq_done, and clear the counter and idx.
REQ-020 If soft_rst_req=1 in HOLD, RELEASE or RUN, the next edge SHALL enter ASSERT with the same effects as REQ-019.
REQ-021 soft_rst_req SHALL be ignored in ASSERT.
REQ-022 restart_cnt SHALL increment only on a lock-loss exit from RUN, saturating at 255; soft requests SHALL NOT count.
REQ-023 Priority SHALL be pl_rst > lock loss > soft_rst_req > normal progression.
REQ-024 Once set to 1 by ASSERT, a sub_rst bit SHALL never deassert out of order or glitch low; all outputs SHALL be registered.

Reset
REQ-025 While pl_rst=1, the block SHALL hold: state ASSERT, sub_rst all 1, seq_done 0, seq_state 0, restart_cnt 0, counter 0, idx 0, both sync flops 0.
REQ-026 pl_rst asserted mid-RELEASE or mid-RUN SHALL take effect on the next edge, overriding all other inputs.
REQ-027 restart_cnt SHALL be cleared only by pl_rst.

Structure
REQ-028 State encodings and the restart_cnt width SHALL reside in shared package rst_seq_pkg.
REQ-029 The lock_in synchroniser SHALL be a separate sub-module, sync_2ff, one bit wide with synchronous reset.
REQ-030 Counter width SHALL be clog2 of max(HOLD_CYC, STAGE_CYC); idx width SHALL be clog2(NUM_RST)+1.

Verification (defaults NUM_RST=4, HOLD_CYC=16, STAGE_CYC=8)
REQ-031 Nominal: release pl_rst, raise lock_in -> sub_rst 1111->1110->1100->1000->0000 at T0+24/32/40/48, and seq_done=1 at T0+48.
REQ-032 Lock glitch in HOLD: drop lock_in for 3 cycles at T0+10 -> ASSERT, sub_rst=1111, full sequence restarts, restart_cnt remains 0.
REQ-033 Lock loss in RUN -> sub_rst=1111 and seq_done=0 next edge, restart_cnt=1; after 300 such losses, restart_cnt=255.
REQ-034 soft_rst_req pulse in RUN -> ASSERT, restart_cnt unchanged; the same pulse in ASSERT causes no effect.
REQ-035 pl_rst plus soft_rst_req plus lock drop at T0+30 in the same cycle -> reset values per REQ-025, restart_cnt=0.
REQ-036 Parameter sweep NUM_RST=1, HOLD_CYC=1, STAGE_CYC=1 -> sub_rst[0] low and seq_done high at T0+2.
